attempt_sequencer: RTL

ATTEMPT_SEQUENCER -- requirements
Module: attempt_sequencer

---
 rtl/attempt_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/attempt_sequencer.sv
// Gates receive strobes to the matcher, forwards its verdict to UART TX and, when
// ATTEMPT_LOCKOUT_EN is defined, locks out after MAX_FAILS consecutive failures.
module attempt_sequencer #(
    parameter logic [3:0]  MAX_FAILS      = 4'd3,
    parameter logic [23:0] LOCKOUT_CYCLES = 24'd12000000
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_bit_valid_in,
    input  logic rx_byte_start_in,
    output logic m_rx_bit_valid_now,
    output logic m_rx_byte_start,
    input  logic m_tx_trigger,
    input  logic m_tx_which_byte,
    output logic m_tx_done,
    output logic tx_trigger,
    output logic tx_which_byte,
    input  logic tx_done,
    output logic locked
);

    typedef enum logic [2:0] {
        ST_PASS,
        ST_RESULT,
        ST_TXWAIT,
        ST_LOCKOUT,
        ST_NAKWAIT
    } state_t;

    state_t state_p0, state_nx;
    logic   which_p0, which_nx;
    logic   trig_p0, trig_nx;
    logic   mdone_p0, mdone_nx;

`ifdef ATTEMPT_LOCKOUT_EN
    localparam logic [3:0]  FAIL_LIMIT = (MAX_FAILS == 4'd0) ? 4'd1 : MAX_FAILS;
    localparam logic [23:0] TIMER_LOAD = (LOCKOUT_CYCLES == 24'd0) ? 24'd0
                                                                   : LOCKOUT_CYCLES - 24'd1;

    logic [3:0]  fail_cnt_p0, fail_cnt_nx, fail_inc;
    logic [23:0] timer_p0, timer_nx;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [23:0] sat_dec24(input logic [23:0] v);
        return (v == 24'd0) ? v : v - 24'd1;
    endfunction

    assign fail_inc = sat_inc4(fail_cnt_p0);
`else
    logic cfg_unused;
    assign cfg_unused = ^{MAX_FAILS, LOCKOUT_CYCLES};
`endif

    always_comb begin
        state_nx = state_p0;
        which_nx = which_p0;
        trig_nx  = 1'b0;
        mdone_nx = 1'b0;
`ifdef ATTEMPT_LOCKOUT_EN
        fail_cnt_nx = fail_cnt_p0;
        timer_nx    = timer_p0;
`endif
        case (state_p0)
            ST_PASS: begin
                if (m_tx_trigger) begin
                    which_nx = m_tx_which_byte;
                    trig_nx  = 1'b1;
                    state_nx = ST_RESULT;
                end
            end
            ST_RESULT: state_nx = ST_TXWAIT;
            ST_TXWAIT: begin
                if (tx_done) begin
                    mdone_nx = 1'b1;
                    state_nx = ST_PASS;
`ifdef ATTEMPT_LOCKOUT_EN
                    // which_p0 still holds the verdict captured when this send began
                    if (which_p0) begin
                        fail_cnt_nx = 4'd0;
                    end else if (fail_inc >= FAIL_LIMIT) begin
                        fail_cnt_nx = 4'd0;
                        timer_nx    = TIMER_LOAD;
                        state_nx    = ST_LOCKOUT;
                    end else begin
                        fail_cnt_nx = fail_inc;
                    end
`endif
                end
            end
`ifdef ATTEMPT_LOCKOUT_EN
            ST_LOCKOUT: begin
                // expiry takes priority over a byte start arriving on the same cycle
                if (timer_p0 == 24'd0) begin
                    state_nx = ST_PASS;
                end else begin
                    timer_nx = timer_p0 - 24'd1;
                    if (rx_bit_valid_in && rx_byte_start_in) begin
                        which_nx = 1'b0;
                        trig_nx  = 1'b1;
                        state_nx = ST_NAKWAIT;
                    end
                end
            end
            ST_NAKWAIT: begin
                timer_nx = sat_dec24(timer_p0);
                if (tx_done) state_nx = (timer_p0 != 24'd0) ? ST_LOCKOUT : ST_PASS;
            end
`endif
            default: state_nx = ST_PASS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= ST_PASS;
            which_p0 <= 1'b1;
            trig_p0  <= 1'b0;
            mdone_p0 <= 1'b0;
`ifdef ATTEMPT_LOCKOUT_EN
            fail_cnt_p0 <= 4'd0;
            timer_p0    <= 24'd0;
`endif
        end else begin
            state_p0 <= state_nx;
            which_p0 <= which_nx;
            trig_p0  <= trig_nx;
            mdone_p0 <= mdone_nx;
`ifdef ATTEMPT_LOCKOUT_EN
            fail_cnt_p0 <= fail_cnt_nx;
            timer_p0    <= timer_nx;
`endif
        end
    end

    assign m_rx_bit_valid_now = (state_p0 == ST_PASS) && rx_bit_valid_in;
    assign m_rx_byte_start    = (state_p0 == ST_PASS) && rx_byte_start_in;
    assign tx_trigger         = trig_p0;
    assign tx_which_byte      = which_p0;
    // held high for the whole reset so an un-reset matcher drops back to idle
    assign m_tx_done          = rst || mdone_p0;
`ifdef ATTEMPT_LOCKOUT_EN
    assign locked = (state_p0 == ST_LOCKOUT) || (state_p0 == ST_NAKWAIT);
`else
    assign locked = 1'b0;
`endif

endmodule
